// File: rtl/fixed_to_decimal_400bit_if.sv
// ---------------------------------------------------------------------------
// fixed_to_decimal_400bit_if
// Bundles the request and digit-stream signals of fixed_to_decimal_400bit.
//   start, value       : conversion request and fixed-point operand
//   busy, int_part     : conversion in progress, latched integer part
//   digit_valid/ready  : valid/ready handshake for the BCD digit stream
//   digit, digit_index : BCD digit and its position after the decimal point
//   done               : one-cycle pulse after the final digit handshake
// Modports: master = requester/consumer side, slave = converter side.
// ---------------------------------------------------------------------------
interface fixed_to_decimal_400bit_if #(
  parameter int WIDTH    = 400,
  parameter int INT_BITS = 8,
  parameter int IDX_W    = 7
);
  logic                start;
  logic [WIDTH-1:0]    value;
  logic                busy;
  logic [INT_BITS-1:0] int_part;
  logic                digit_valid;
  logic [3:0]          digit;
  logic [IDX_W-1:0]    digit_index;
  logic                digit_ready;
  logic                done;

  modport master (
    output start, value, digit_ready,
    input  busy, int_part, digit_valid, digit, digit_index, done
  );

  modport slave (
    input  start, value, digit_ready,
    output busy, int_part, digit_valid, digit, digit_index, done
  );
endinterface

// File: rtl/fixed_to_decimal_400bit.sv
// ---------------------------------------------------------------------------
// fixed_to_decimal_400bit
// Converts an unsigned 8.392 fixed-point value into a binary integer part and
// a stream of NUM_DIGITS BCD fraction digits. Each digit is the integer
// carry-out of multiplying the remaining fraction by ten (truncating).
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave modport of fixed_to_decimal_400bit_if (request, latched
//           integer part, digit valid/ready stream, busy and done)
// All outputs are driven directly from registers.
// ---------------------------------------------------------------------------
module fixed_to_decimal_400bit #(
  parameter int WIDTH      = 400,
  parameter int INT_BITS   = 8,
  parameter int NUM_DIGITS = 110,
  parameter int IDX_W      = 7
) (
  input  logic                      clk,
  input  logic                      rst_n,
  fixed_to_decimal_400bit_if.slave  bus
);

  localparam int FRAC = WIDTH - INT_BITS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OUT  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Multiply a fraction by ten as (f<<3)+(f<<1); top 4 bits are the digit,
  // the low FRAC bits are the remaining fraction. Cannot exceed 9 in the top.
  function automatic logic [FRAC+3:0] mul10(input logic [FRAC-1:0] f);
    logic [FRAC+3:0] w;
    w = {4'b0000, f};
    return (w << 3'd3) + (w << 3'd1);
  endfunction

  state_t              state_r, state_s;
  logic [INT_BITS-1:0] int_r, int_s;
  logic [FRAC-1:0]     frac_r, frac_s;
  logic [3:0]          digit_r, digit_s;
  logic [IDX_W-1:0]    idx_r, idx_s;
  logic                valid_r, valid_s;
  logic                done_r, done_s;
  logic                busy_r, busy_s;

  logic [FRAC+3:0]     step_in_s;
  logic [FRAC+3:0]     step_fr_s;
  logic                hs_s;
  logic                last_s;

  assign step_in_s = mul10(bus.value[FRAC-1:0]);
  assign step_fr_s = mul10(frac_r);
  assign hs_s      = valid_r & bus.digit_ready;
  assign last_s    = (idx_r == IDX_W'(NUM_DIGITS - 1));

  // State register and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      int_r   <= '0;
      frac_r  <= '0;
      digit_r <= 4'd0;
      idx_r   <= '0;
      valid_r <= 1'b0;
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      int_r   <= int_s;
      frac_r  <= frac_s;
      digit_r <= digit_s;
      idx_r   <= idx_s;
      valid_r <= valid_s;
      done_r  <= done_s;
      busy_r  <= busy_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.start) state_s = OUT;
        else           state_s = IDLE;
      end
      OUT: begin
        if (hs_s && last_s) state_s = FIN;
        else                state_s = OUT;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Next values of the output and datapath registers; everything holds unless
  // the current state advances it, which gives back-pressure for free.
  always_comb begin
    int_s   = int_r;
    frac_s  = frac_r;
    digit_s = digit_r;
    idx_s   = idx_r;
    valid_s = valid_r;
    done_s  = done_r;
    busy_s  = busy_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          int_s   = bus.value[WIDTH-1:FRAC];
          digit_s = step_in_s[FRAC+3:FRAC];
          frac_s  = step_in_s[FRAC-1:0];
          idx_s   = '0;
          valid_s = 1'b1;
          busy_s  = 1'b1;
        end else begin
          valid_s = 1'b0;
        end
      end
      OUT: begin
        if (hs_s && last_s) begin
          valid_s = 1'b0;
          done_s  = 1'b1;
        end else if (hs_s) begin
          digit_s = step_fr_s[FRAC+3:FRAC];
          frac_s  = step_fr_s[FRAC-1:0];
          idx_s   = idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
          valid_s = 1'b1;
        end
      end
      FIN: begin
        done_s = 1'b0;
        busy_s = 1'b0;
      end
      default: begin
        valid_s = 1'b0;
        done_s  = 1'b0;
        busy_s  = 1'b0;
      end
    endcase
  end

  assign bus.busy        = busy_r;
  assign bus.int_part    = int_r;
  assign bus.digit_valid = valid_r;
  assign bus.digit       = digit_r;
  assign bus.digit_index = idx_r;
  assign bus.done        = done_r;

endmodule

// File: tb/tb_fixed_to_decimal_400bit.sv
// ---------------------------------------------------------------------------
// tb_fixed_to_decimal_400bit
// Self-checking bench: table of conversion vectors plus hand-written
// back-pressure, start-during-stream and mid-stream reset sequences. Expected
// digits go into a scoreboard queue when a conversion is started and are
// popped on every digit handshake.
// ---------------------------------------------------------------------------
module tb_fixed_to_decimal_400bit;
  localparam int NUM = 110;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fixed_to_decimal_400bit_if bif ();

  fixed_to_decimal_400bit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bif)
  );

  typedef struct {
    logic [3:0] d;
    logic [6:0] idx;
  } exp_t;

  typedef struct {
    logic [399:0] value;
    logic [7:0]   exp_int;
    logic [3:0]   d0;
    logic [3:0]   drest;
    bit           use_model;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[5];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Expected digits: either constants from the table or long multiplication.
  task automatic push_exp(input logic [399:0] v, input logic [3:0] d0,
                          input logic [3:0] drest, input bit use_model);
    logic [391:0] f;
    logic [395:0] w;
    exp_t e;
    f = v[391:0];
    for (int i = 0; i < NUM; i++) begin
      if (use_model) begin
        w = {4'd0, f} * 4'd10;
        e.d = w[395:392];
        f = w[391:0];
      end else begin
        e.d = (i == 0) ? d0 : drest;
      end
      e.idx = 7'(i);
      sb.push_back(e);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the start edge.
  task automatic start_conv(input logic [399:0] v, input logic [7:0] exp_int,
                            input logic [3:0] d0, input logic [3:0] drest,
                            input bit use_model);
    chk("pre_busy", 32'(bif.busy), 32'd0);
    chk("pre_valid", 32'(bif.digit_valid), 32'd0);
    bif.value = v;
    bif.start = 1'b1;
    push_exp(v, d0, drest, use_model);
    @(negedge clk);
    bif.start = 1'b0;
    bif.value = ~v;
    chk("first_valid", 32'(bif.digit_valid), 32'd1);
    chk("busy_after_start", 32'(bif.busy), 32'd1);
    chk("int_part", 32'(bif.int_part), 32'(exp_int));
  endtask

  // Drives digit_ready, checks every presented digit against the scoreboard,
  // then checks the done/busy tail. Returns at a negedge in IDLE.
  task automatic stream(input logic [7:0] exp_int, input int stall, input bit toggle,
                        input int inject_at, input int abort_at);
    int   cyc = 0;
    int   hs = 0;
    exp_t e;
    while (hs < NUM && cyc < 4 * NUM + 50) begin
      if (abort_at >= 0 && hs == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk("rst_busy", 32'(bif.busy), 32'd0);
        chk("rst_valid", 32'(bif.digit_valid), 32'd0);
        chk("rst_done", 32'(bif.done), 32'd0);
        chk("rst_digit", 32'(bif.digit), 32'd0);
        chk("rst_index", 32'(bif.digit_index), 32'd0);
        chk("rst_int", 32'(bif.int_part), 32'd0);
        sb.delete();
        bif.digit_ready = 1'b0;
        bif.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      bif.digit_ready = (cyc < stall) ? 1'b0 : (toggle ? ((cyc - stall) % 2 == 0) : 1'b1);
      bif.start = (cyc == inject_at);
      if (cyc == inject_at) bif.value = {8'h77, {98{4'h9}}};
      chk("valid_in_out", 32'(bif.digit_valid), 32'd1);
      chk("digit_le_9", 32'(bif.digit <= 4'd9), 32'd1);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_underflow actual=digit_at_index_%0d expected=no_digit", bif.digit_index);
      end else begin
        e = sb[0];
        chk("digit", 32'(bif.digit), 32'(e.d));
        chk("index", 32'(bif.digit_index), 32'(e.idx));
      end
      if (bif.digit_valid && bif.digit_ready) begin
        if (sb.size() != 0) void'(sb.pop_front());
        hs++;
      end
      @(negedge clk);
      cyc++;
    end
    bif.start = 1'b0;
    bif.digit_ready = 1'b0;
    chk("handshakes", 32'(hs), 32'(NUM));
    if (stall == 0 && !toggle) chk("throughput_cycles", 32'(cyc), 32'(NUM));
    chk("fin_done", 32'(bif.done), 32'd1);
    chk("fin_busy", 32'(bif.busy), 32'd1);
    chk("fin_valid", 32'(bif.digit_valid), 32'd0);
    chk("int_held", 32'(bif.int_part), 32'(exp_int));
    @(negedge clk);
    chk("idle_done", 32'(bif.done), 32'd0);
    chk("idle_busy", 32'(bif.busy), 32'd0);
    chk("idle_valid", 32'(bif.digit_valid), 32'd0);
    chk("sb_leftover", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    logic [399:0] one, half, third, nines, rnd;
    one = '0;   one[392] = 1'b1;
    half = '0;  half[391] = 1'b1;
    third = {8'd2, {196{2'b01}}};
    nines = {8'd0, {392{1'b1}}};
    rnd = '0;
    for (int i = 0; i < 13; i++) rnd = (rnd << 32) | 400'($urandom);
    rnd[399:392] = 8'hA5;

    vecs[0] = '{one,   8'd1,   4'd0, 4'd0, 1'b0};
    vecs[1] = '{half,  8'd0,   4'd5, 4'd0, 1'b0};
    vecs[2] = '{third, 8'd2,   4'd3, 4'd3, 1'b0};
    vecs[3] = '{nines, 8'd0,   4'd9, 4'd9, 1'b0};
    vecs[4] = '{rnd,   8'hA5,  4'd0, 4'd0, 1'b1};

    rst_n = 1'b0;
    bif.start = 1'b0;
    bif.value = '0;
    bif.digit_ready = 1'b0;
    #12;
    chk("reset_busy", 32'(bif.busy), 32'd0);
    chk("reset_valid", 32'(bif.digit_valid), 32'd0);
    chk("reset_done", 32'(bif.done), 32'd0);
    chk("reset_digit", 32'(bif.digit), 32'd0);
    chk("reset_index", 32'(bif.digit_index), 32'd0);
    chk("reset_int", 32'(bif.int_part), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 5; v++) begin
      start_conv(vecs[v].value, vecs[v].exp_int, vecs[v].d0, vecs[v].drest, vecs[v].use_model);
      stream(vecs[v].exp_int, 0, 1'b0, -1, -1);
    end

    // Back-pressure: five stalled cycles at index 0, then alternating ready.
    start_conv(half, 8'd0, 4'd5, 4'd0, 1'b0);
    stream(8'd0, 5, 1'b1, -1, -1);

    // start during the stream is ignored; start in first IDLE cycle is taken.
    start_conv(third, 8'd2, 4'd3, 4'd3, 1'b0);
    stream(8'd2, 0, 1'b0, 10, -1);
    start_conv(one, 8'd1, 4'd0, 4'd0, 1'b0);
    stream(8'd1, 0, 1'b0, -1, -1);

    // Reset at index 40, then a clean conversion.
    start_conv(half, 8'd0, 4'd5, 4'd0, 1'b0);
    stream(8'd0, 0, 1'b0, -1, 40);
    @(negedge clk);
    start_conv(one, 8'd1, 4'd0, 4'd0, 1'b0);
    stream(8'd1, 0, 1'b0, -1, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fixed_to_decimal_400bit.md
Name: fixed_to_decimal_400bit

Overview:
Converts a 400-bit unsigned fixed-point value into decimal form. The value is formatted as 8 integer bits and 392 fraction bits, so 1.0 is 1<<392. This is the format divider_400bit produces.
The block latches the value and presents the integer part as binary. It then streams NUM_DIGITS fraction digits as BCD over a valid/ready handshake, generating each digit by repeatedly multiplying the remaining fraction by 10.
It sits downstream of divider_400bit and feeds the digit display/UART path.

Parameters:
WIDTH, 400, total fixed-point width
INT_BITS, 8, integer bits (MSBs); fraction width FRAC = WIDTH-INT_BITS = 392
NUM_DIGITS, 110, decimal fraction digits emitted per conversion (1..118)
IDX_W, 7, width of digit_index; must satisfy 2^IDX_W >= NUM_DIGITS

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
value  input  WIDTH  fixed-point operand; sampled on the accepted start edge
busy  output  1  high from start acceptance until the done cycle, inclusive
int_part  output  INT_BITS  value[WIDTH-1:FRAC], latched at start; held until the next start
digit_valid  output  1  a digit is presented
digit  output  4  BCD digit, 0..9
digit_index  output  IDX_W  0-based position after the decimal point
digit_ready  input  1  consumer accepts the digit
done  output  1  one-cycle pulse after the last digit handshake

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy, digit_valid, done=0; digit, digit_index, int_part=0; fraction register=0. Takes effect immediately, including mid-stream; any partial stream is abandoned.
- Multiply step, purely combinational on a FRAC-bit fraction f:
  - p = (f<<3)+(f<<1), FRAC+4 bits wide.
  - next digit = p[FRAC+3:FRAC].
  - next fraction = p[FRAC-1:0].
  - The result is a truncating floor; no rounding.
- States: IDLE, OUT, FIN.
- IDLE:
  - On an edge with start=1:
    - int_part <= value[WIDTH-1:FRAC].
    - digit/fraction register <= multiply step applied to value[FRAC-1:0].
    - digit_index <= 0; digit_valid <= 1; busy <= 1; go to OUT.
  - Latency: the first digit is valid in the cycle immediately after the start edge.
- OUT:
  - Handshake = digit_valid & digit_ready at a rising edge.
  - On handshake with digit_index < NUM_DIGITS-1: digit/fraction <= multiply step on the fraction register; digit_index += 1; digit_valid stays 1. Throughput is 1 digit/cycle with digit_ready held high.
  - On handshake with digit_index == NUM_DIGITS-1: digit_valid <= 0; done <= 1; go to FIN.
  - With no handshake: digit, digit_index and fraction hold stable (back-pressure).
- FIN: done=1 for exactly this cycle, busy=1. Next edge: done <= 0, busy <= 0, go to IDLE.
- start is ignored in OUT and FIN. It is accepted again in the first IDLE cycle, i.e. 2 edges after the last handshake.
- digit_ready is ignored whenever digit_valid=0.
- digit never exceeds 9, because f < 2^FRAC implies p < 10*2^FRAC.
- int_part is not decimal-converted; the consumer formats it.

Test Plan:
1. value=1<<392 (1.0), digit_ready=1 -> int_part=1; 110 digits all 0, digit_index 0..109 on consecutive cycles; done pulses once 1 cycle after index 109; busy falls with it.
2. value=1<<391 (0.5) -> int_part=0; digits 5,0,0,...; with start at edge T0, digit_valid=1 in the cycle after T0.
3. value={8'd2, 392-bit repeating 0101...} (2+1/3-ε) -> int_part=2; all 110 digits 3. Then fraction all ones -> all 110 digits 9, never >9.
4. Back-pressure: value=1<<391; digit_ready low for 5 cycles at index 0, then toggling 1/0 -> digit=5, index=0 held stable while stalled; no digit skipped or duplicated; exactly 110 handshakes.
5. start pulsed again during OUT -> ignored; stream completes unchanged. start in the first IDLE cycle after done -> new conversion accepted.
6. rst_n low at digit_index=40 -> all outputs 0 immediately. After release, a new start with value=1<<392 produces a clean 110-digit stream.
